// File: rtl/ch8_mem_arbiter.sv
// ch8_mem_arbiter: 3-way round-robin CHIP-8 RAM arbiter with a bounded bus lock
module ch8_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [2:0]  lock,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [11:0] addr2,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic [7:0]  wdata2,
  output logic [2:0]  gnt,
  output logic [2:0]  rvalid,
  output logic [7:0]  rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t     state, state_n;
  logic [1:0] last, last_n, owner, owner_n;
  logic [4:0] lock_cnt, lock_cnt_n;
  logic [2:0] rv_q, rv_n;
  logic [1:0] p0, p1, p2, rr_idx, gi;
  logic       owner_req, hit;
  always_comb begin
    p0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
    p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    rr_idx = req[p0] ? p0 : req[p1] ? p1 : p2;
    owner_req = (state == LOCKED) && req[owner];
    gi = owner_req ? owner : rr_idx;
    hit = !reset && (owner_req || |req);
    gnt = hit ? 3'b001 << gi : 3'b000;
  end
  always_comb begin
    mem_en = hit;
    mem_we = hit && we[gi];
    mem_addr = gnt[0] ? addr0 : gnt[1] ? addr1 : gnt[2] ? addr2 : 12'h000;
    mem_wdata = gnt[0] ? wdata0 : gnt[1] ? wdata1 : gnt[2] ? wdata2 : 8'h00;
    rvalid = reset ? 3'b000 : rv_q;
    rdata = mem_rdata;
  end
  // The 16th consecutive owner grant (count 15 -> 16) forcibly ends the lock.
  always_comb begin
    state_n = ARB;
    last_n = last;
    owner_n = owner;
    lock_cnt_n = 5'd0;
    rv_n = (hit && !we[gi]) ? gnt : 3'b000;
    if (hit) begin
      last_n = gi;
      if (owner_req) begin
        lock_cnt_n = lock_cnt + 5'd1;
        state_n = (lock[gi] && lock_cnt != 5'd15) ? LOCKED : ARB;
      end else begin
        state_n = lock[gi] ? LOCKED : ARB;
        owner_n = lock[gi] ? gi : owner;
        lock_cnt_n = lock[gi] ? 5'd1 : 5'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      last <= 2'd2;
      owner <= 2'd0;
      lock_cnt <= 5'd0;
      rv_q <= 3'b000;
    end else begin
      state <= state_n;
      last <= last_n;
      owner <= owner_n;
      lock_cnt <= lock_cnt_n;
      rv_q <= rv_n;
    end
  end
endmodule

// File: tb/tb_ch8_mem_arbiter.sv
// tb_ch8_mem_arbiter: directed + randomized check of ch8_mem_arbiter against a behavioural model
module tb_ch8_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic [2:0]  req, we, lock, gnt, rvalid;
  logic [11:0] addr0, addr1, addr2, mem_addr;
  logic [7:0]  wdata0, wdata1, wdata2, rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  ch8_mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + (a >> 4));
  endfunction
  logic [7:0] ram [4096];
  logic [7:0] ram_q;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_q <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else ram_q <= ram[mem_addr];
    end
  end
  int n_vec = 0, n_err = 0;
  int m_last = 2, m_owner = 0, m_cnt = 0;
  bit m_locked = 0;
  logic [2:0] m_rv = 3'b000;
  logic [7:0] m_rd = 8'h00;
  logic [7:0] ref_mem [4096];
  logic [2:0] o_gnt, o_rv, e_gnt;
  logic [7:0] o_rdata;
  logic [11:0] o_addr;
  logic o_we;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] addr_of(input int k);
    return k == 0 ? addr0 : k == 1 ? addr1 : addr2;
  endfunction
  function automatic logic [7:0] wdata_of(input int k);
    return k == 0 ? wdata0 : k == 1 ? wdata1 : wdata2;
  endfunction
  task automatic drv(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    req = r;
    we = w;
    lock = l;
  endtask
  task automatic step();
    int eg;
    logic ew;
    logic [11:0] ea;
    logic [7:0] ed;
    #1;
    eg = -1;
    if (!reset) begin
      if (m_locked && req[m_owner]) eg = m_owner;
      else for (int i = 1; i <= 3; i++) if (eg < 0 && req[(m_last + i) % 3]) eg = (m_last + i) % 3;
    end
    e_gnt = (eg < 0) ? 3'b000 : 3'(1 << eg);
    ew = (eg >= 0) ? we[eg] : 1'b0;
    ea = (eg >= 0) ? addr_of(eg) : 12'h000;
    ed = (eg >= 0) ? wdata_of(eg) : 8'h00;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rvalid", 32'(rvalid), reset ? 32'd0 : 32'(m_rv));
    chk("mem_en", 32'(mem_en), (eg >= 0) ? 32'd1 : 32'd0);
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", 32'(mem_wdata), 32'(ed));
    if (!reset && m_rv != 3'b000) chk("rdata", 32'(rdata), 32'(m_rd));
    o_gnt = gnt;
    o_rv = rvalid;
    o_rdata = rdata;
    o_addr = mem_addr;
    o_we = mem_we;
    @(posedge clk);
    if (reset) begin
      m_last = 2;
      m_locked = 0;
      m_owner = 0;
      m_cnt = 0;
      m_rv = 3'b000;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    end else begin
      m_rv = (eg >= 0 && !ew) ? e_gnt : 3'b000;
      if (eg >= 0) begin
        if (ew) ref_mem[ea] = ed;
        else m_rd = ref_mem[ea];
        if (m_locked && eg == m_owner) begin
          m_cnt++;
          m_locked = lock[eg] && m_cnt < 16;
        end else begin
          m_owner = eg;
          m_cnt = 1;
          m_locked = lock[eg];
        end
        m_last = eg;
      end else m_locked = 0;
    end
    #1;
  endtask
  logic [2:0] rr_seq [6];
  logic rq [3], rw [3], rl [3];
  logic [11:0] ra [3];
  logic [7:0] rdd [3];
  int n0;
  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset = 1'b1;
    drv(3'b000, 3'b000, 3'b000);
    addr0 = 12'h000; addr1 = 12'h000; addr2 = 12'h000;
    wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
    step();
    drv(3'b111, 3'b111, 3'b111);
    addr1 = 12'h5A5; wdata1 = 8'h3C;
    step();
    chk("reset_gnt", 32'(o_gnt), 32'd0);
    reset = 1'b0;
    drv(3'b111, 3'b000, 3'b000);
    addr0 = 12'h010; addr1 = 12'h2A7; addr2 = 12'hFFE;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", 32'(o_gnt), 32'(rr_seq[i]));
    end
    drv(3'b011, 3'b000, 3'b001);
    addr0 = 12'h200; addr1 = 12'h345;
    step();
    chk("lk_gnt0", 32'(o_gnt), 32'd1);
    chk("lk_addr0", 32'(o_addr), 32'h200);
    addr0 = 12'h201;
    lock = 3'b000;
    step();
    chk("lk_gnt1", 32'(o_gnt), 32'd1);
    chk("lk_addr1", 32'(o_addr), 32'h201);
    drv(3'b010, 3'b000, 3'b000);
    step();
    chk("lk_gnt2", 32'(o_gnt), 32'd2);
    chk("lk_addr2", 32'(o_addr), 32'h345);
    drv(3'b011, 3'b000, 3'b001);
    n0 = 0;
    for (int i = 0; i < 16; i++) begin
      addr0 = 12'(12'h300 + i);
      step();
      if (o_gnt == 3'b001) n0++;
    end
    chk("lock16", n0, 16);
    step();
    chk("starve_gnt", 32'(o_gnt), 32'd2);
    step();
    chk("regrant", 32'(o_gnt), 32'd1);
    step();
    step();
    drv(3'b100, 3'b000, 3'b000);
    step();
    chk("drop_gnt", 32'(o_gnt), 32'd4);
    drv(3'b010, 3'b000, 3'b000);
    step();
    chk("after_drop", 32'(o_gnt), 32'd2);
    drv(3'b100, 3'b100, 3'b000);
    addr2 = 12'hFFF; wdata2 = 8'hAB;
    step();
    chk("wr_we", 32'(o_we), 32'd1);
    chk("wr_addr", 32'(o_addr), 32'hFFF);
    drv(3'b001, 3'b000, 3'b000);
    addr0 = 12'hFFF;
    step();
    chk("wr_no_rv", 32'(o_rv), 32'd0);
    chk("rd_we", 32'(o_we), 32'd0);
    drv(3'b000, 3'b000, 3'b000);
    step();
    chk("rd_rv", 32'(o_rv), 32'd1);
    chk("rd_data", 32'(o_rdata), 32'hAB);
    drv(3'b001, 3'b000, 3'b001);
    addr0 = 12'h200;
    step();
    chk("pre_rst_gnt", 32'(o_gnt), 32'd1);
    reset = 1'b1;
    drv(3'b000, 3'b000, 3'b000);
    step();
    chk("rst_rv", 32'(o_rv), 32'd0);
    reset = 1'b0;
    drv(3'b110, 3'b000, 3'b000);
    step();
    chk("post_rst", 32'(o_gnt), 32'd2);
    for (int k = 0; k < 3; k++) begin
      rq[k] = 1'b0; rw[k] = 1'b0; rl[k] = 1'b0; ra[k] = 12'h000; rdd[k] = 8'h00;
    end
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (e_gnt[k] || !rq[k]) begin
          rq[k] = $urandom_range(0, 99) < 65;
          rw[k] = $urandom_range(0, 2) == 0;
          rl[k] = $urandom_range(0, 2) == 0;
          ra[k] = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15)) : 12'($urandom_range(0, 4095));
          rdd[k] = 8'($urandom_range(0, 255));
        end
      end
      reset = $urandom_range(0, 99) == 0;
      req = {rq[2], rq[1], rq[0]};
      we = {rw[2], rw[1], rw[0]};
      lock = {rl[2], rl[1], rl[0]};
      addr0 = ra[0]; addr1 = ra[1]; addr2 = ra[2];
      wdata0 = rdd[0]; wdata1 = rdd[1]; wdata2 = rdd[2];
      step();
      if (reset) e_gnt = 3'b000;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
